// File: rtl/mem_arbiter.sv
// Arbiter for the shared single-ported I/D memory: one transaction at a time,
// D-priority with a bounded D streak, ack timeout, done/err pulses and stage stalls.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_done,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                err,
  output logic                stall_F,
  output logic                stall_M,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = ($clog2(MAX_D_STREAK + 1) > 3) ? $clog2(MAX_D_STREAK + 1) : 3;

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              streak_full;

  assign streak_full = (streak_q == SW'(MAX_D_STREAK));

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (d_req && !(i_req && streak_full)) begin
          state_d     = BUSY_D;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_we ? d_be : '0;
          cnt_d       = '0;
          err_d       = 1'b0;
          if (!i_req)           streak_d = '0;
          else if (!streak_full) streak_d = streak_q + 1'b1;
        end else if (i_req) begin
          state_d     = BUSY_I;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_be_d    = '0;
          cnt_d       = '0;
          err_d       = 1'b0;
          streak_d    = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        // An ack in the final timeout cycle still wins over the abort.
        if (mem_ack) begin
          if (state_q == BUSY_I)  i_rdata_d = mem_rdata;
          else if (!mem_we_q)     d_rdata_d = mem_rdata;
          state_d = (state_q == BUSY_I) ? RESP_I : RESP_D;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          err_d = 1'b1;
          if (state_q == BUSY_I) i_rdata_d = '0;
          else                   d_rdata_d = '0;
          state_d = (state_q == BUSY_I) ? RESP_I : RESP_D;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP_I, RESP_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // mem_req decodes straight from state so an async reset drops it at once.
  assign mem_req   = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign i_done    = (state_q == RESP_I);
  assign d_done    = (state_q == RESP_D);
  assign err       = err_q && (i_done || d_done);
  assign stall_F   = i_req & ~i_done;
  assign stall_M   = d_req & ~d_done;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported unified instruction/data memory between the fetch stage (I port, read-only) and the memory stage (D port, read/write). It sequences one memory transaction at a time through a req/ack handshake. It returns read data and a one-cycle done pulse to the winning requester. It also drives per-stage stall requests into the pipeline hazard logic while a stage waits for memory.

## Interface
Parameters:
- ADDR_W, 32, address width of both requesters and memory
- DATA_W, 32, data width; byte mask width is DATA_W/8
- MAX_D_STREAK, 4, consecutive D grants allowed while I is pending before I is forced to win
- TIMEOUT, 255, cycles to wait for mem_ack before aborting (8-bit counter; TIMEOUT must be >= 1)

Ports:
- clk  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-low (0 = reset)
- i_req  in  1  fetch request; held high with i_addr stable until i_done
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetch read data, valid with i_done, held until the next I completion
- i_done  out  1  one-cycle completion pulse for the I port
- d_req  in  1  data request; held high with d_* stable until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_be  in  DATA_W/8  byte enables, writes only (forced 0 to memory on reads)
- d_rdata  out  DATA_W  data read data, valid with d_done
- d_done  out  1  one-cycle completion pulse for the D port
- err  out  1  one-cycle pulse alongside a done that ended by timeout
- stall_F  out  1  i_req & ~i_done
- stall_M  out  1  d_req & ~d_done
- mem_req  out  1  memory request, high in BUSY_I/BUSY_D
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  registered command, stable while mem_req
- mem_ack  in  1  memory completion; may arrive in the same cycle as the first mem_req
- mem_rdata  in  DATA_W  valid when mem_ack and the command is a read

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE, no req: stay.
- IDLE, only one req: grant it.
- IDLE, both reqs: grant D, unless streak == MAX_D_STREAK, then grant I.
- On grant: latch the command into the mem_* registers, clear the timeout counter, and go to BUSY_x.
- For an I grant the mem command is: mem_we=0, mem_be=0, mem_wdata=0.
- streak counter (3-bit min, saturating at MAX_D_STREAK):
  - on a D grant with i_req high: increment
  - on any I grant: clear
  - on a D grant with i_req low: clear
- BUSY_x with mem_ack: capture mem_rdata into x_rdata on reads (d_rdata is unchanged on writes), then go to RESP_x.
- BUSY_x without mem_ack: counter increments. When counter == TIMEOUT, go to RESP_x with err pending and x_rdata set to 0.
- RESP_x: assert x_done, plus err if the transaction timed out, then go to IDLE unconditionally.
  - The requester drops or replaces its req at the next edge.
  - No regrant happens from RESP.
- A req deasserted while in BUSY is a protocol violation. The transaction completes anyway.
- Reset values: state=IDLE, all outputs 0, streak=0, counter=0.
  - Reset mid-transaction aborts immediately.
  - mem_req drops asynchronously.
  - No done or err is issued for the aborted transaction.

## Timing
- Grant latency: req sampled high in IDLE at edge n gives mem_req high in cycle n+1.
- With mem_ack in the first BUSY cycle:
  - done is high in cycle n+2
  - IDLE in cycle n+3
  - minimum 3 cycles per transaction; throughput one access per 3 cycles
- Each extra wait cycle of mem_ack adds one cycle.
- Timeout: done+err in cycle n+1+TIMEOUT+1.
- stall_F/stall_M are combinational and drop in the done cycle, so the stage advances at that edge.
- Simultaneous new req on the other port during RESP is arbitrated in the following IDLE cycle.

## Test plan
- Single I read: i_req=1, i_addr=0x100, mem_ack in the first BUSY cycle with mem_rdata=0xDEADBEEF.
  - Expect mem_req in cycle 1, i_done and i_rdata=0xDEADBEEF in cycle 2, stall_F=0 in cycle 2.
- D write with 2 wait states: d_we=1, d_be=0b0011, d_wdata=0x1234.
  - Expect mem_* stable for 3 cycles, d_done in cycle 4, d_rdata unchanged.
- Contention: i_req and d_req held continuously with immediate acks.
  - Expect grants D,D,D,D,I repeating (MAX_D_STREAK=4); streak clears after the I grant.
- Timeout: d_req read with mem_ack never asserted.
  - Expect d_done and err together at cycle TIMEOUT+2, d_rdata=0, FSM back in IDLE.
- Reset mid-BUSY_I: pull reset low.
  - Expect mem_req=0 immediately, no i_done, state IDLE.
  - After release, a new i_req completes normally.
- Same-cycle ack: mem_ack held high permanently with alternating I/D requests.
  - Expect every transaction to take exactly 3 cycles, with no double grant from RESP.
